// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the fetch stage: word width, reset PC and the queue entry layout.
package fetch_stage_pkg;

    localparam int WORD_LEN = 32;
    localparam logic [WORD_LEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [WORD_LEN-1:0] pc;
        logic [WORD_LEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic [WORD_LEN-1:0] next_pc(input logic [WORD_LEN-1:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Generic synchronous FIFO (power-of-2 depth) with synchronous clear.
// Latency: a pushed entry is visible at pop_dat on the next cycle.
// Backpressure: push is dropped only when full and not popping in the same cycle.
module fetch_queue
    import fetch_stage_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = fetch_entry_t
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  T                       push_dat,
    input  logic                   pop,
    output T                       pop_dat,
    input  logic                   clear,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);

    T               mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // Storage carries no reset; pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/fetch_stage.sv
// IF stage + IF/ID register: PC gen, in-order imem req/rsp, prefetch queue. Optional FETCH_PERF_CNT_EN.
// Latency: response -> ID one edge after its push (no bypass); redirect takes effect on the next edge.
// Backpressure: requests gated by queue credit, MAX_OUTST and pending drops; hazard freezes ID, no pop.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [WORD_LEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int                  FQ_DEPTH  = 4,
    parameter int                  MAX_OUTST = 2
) (
    input  logic                clk,
    input  logic                rst,
    output logic                imem_req,
    output logic [WORD_LEN-1:0] imem_addr,
    input  logic                imem_gnt,
    input  logic                imem_rvalid,
    input  logic [WORD_LEN-1:0] imem_rdata,
    input  logic                hazard_detected,
    input  logic                branch_taken,
    input  logic [WORD_LEN-1:0] branch_addr,
    output logic [WORD_LEN-1:0] instr_ID,
    output logic [WORD_LEN-1:0] pc_ID,
    output logic                valid_ID
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]         perf_stall_cnt,
    output logic [31:0]         perf_flush_cnt
`endif
);

    localparam int CW = $clog2(FQ_DEPTH) + 1;

    logic                run;
    logic [WORD_LEN-1:0] pc;
    logic [CW-1:0]       outstanding;
    logic [CW-1:0]       q_count;
    logic [CW-1:0]       drop_cnt;
    logic [CW:0]         inflight;
    logic                hs;
    logic                tag_pop;
    logic                tag_full;
    logic                tag_empty;
    logic [WORD_LEN-1:0] tag_head;
    logic                q_push;
    logic                q_pop;
    logic                q_full;
    logic                q_empty;
    fetch_entry_t        q_in;
    fetch_entry_t        q_head;

    // The tag FIFO occupancy is exactly the number of granted-but-unanswered requests.
    fetch_queue #(.DEPTH(FQ_DEPTH), .T(logic [WORD_LEN-1:0])) u_tag_q (
        .clk      (clk),
        .rst      (rst),
        .push     (hs),
        .push_dat (pc),
        .pop      (tag_pop),
        .pop_dat  (tag_head),
        .clear    (1'b0),
        .count    (outstanding),
        .full     (tag_full),
        .empty    (tag_empty)
    );

    fetch_queue #(.DEPTH(FQ_DEPTH), .T(fetch_entry_t)) u_prefetch_q (
        .clk      (clk),
        .rst      (rst),
        .push     (q_push),
        .push_dat (q_in),
        .pop      (q_pop),
        .pop_dat  (q_head),
        .clear    (branch_taken),
        .count    (q_count),
        .full     (q_full),
        .empty    (q_empty)
    );

    assign inflight  = {1'b0, outstanding} + {1'b0, q_count};
    assign imem_req  = run && !branch_taken
                     && (inflight < (CW+1)'(FQ_DEPTH))
                     && (outstanding < CW'(MAX_OUTST))
                     && (drop_cnt == '0)
                     && !tag_full && !q_full;
    assign imem_addr = pc;
    assign hs        = imem_req && imem_gnt;

    assign tag_pop   = imem_rvalid && !tag_empty;
    assign q_push    = imem_rvalid && (drop_cnt == '0);
    assign q_in      = '{pc: tag_head, instr: imem_rdata};
    assign q_pop     = !branch_taken && !hazard_detected && !q_empty;

    // On redirect no grant can occur, so everything still in flight after this edge is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run      <= 1'b0;
            pc       <= RESET_PC;
            drop_cnt <= '0;
        end else begin
            run <= 1'b1;
            if (branch_taken) begin
                pc       <= branch_addr;
                drop_cnt <= outstanding - CW'(imem_rvalid);
            end else begin
                if (hs) pc <= next_pc(pc);
                if (imem_rvalid && (drop_cnt != '0)) drop_cnt <= drop_cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_ID <= '0;
            pc_ID    <= '0;
            valid_ID <= 1'b0;
        end else if (branch_taken) begin
            valid_ID <= 1'b0;
        end else if (!hazard_detected) begin
            valid_ID <= !q_empty;
            if (!q_empty) begin
                instr_ID <= q_head.instr;
                pc_ID    <= q_head.pc;
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (hazard_detected && valid_ID && (perf_stall_cnt != '1))
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (branch_taken && (perf_flush_cnt != '1))
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage against a queue-based reference model of the fetch pipeline.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    localparam int FQ = 4;
    localparam int MO = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        hazard_detected = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_addr = '0;
    logic [31:0] instr_ID;
    logic [31:0] pc_ID;
    logic        valid_ID;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_flush_cnt;
`endif

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(32'h0), .FQ_DEPTH(FQ), .MAX_OUTST(MO)) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_gnt        (imem_gnt),
        .imem_rvalid     (imem_rvalid),
        .imem_rdata      (imem_rdata),
        .hazard_detected (hazard_detected),
        .branch_taken    (branch_taken),
        .branch_addr     (branch_addr),
        .instr_ID        (instr_ID),
        .pc_ID           (pc_ID),
        .valid_ID        (valid_ID)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_stall_cnt  (perf_stall_cnt),
        .perf_flush_cnt  (perf_flush_cnt)
`endif
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Reference state: memq = addresses granted and not yet answered (also drives the memory),
    // q_m = fetched instructions waiting for ID, drop_m = responses to discard after a redirect.
    logic [31:0]  memq [$];
    fetch_entry_t q_m [$];
    int           drop_m;
    bit           started_m;
    logic [31:0]  fetch_pc_m;
    bit           exp_valid;
    logic [31:0]  exp_pc;
    logic [31:0]  exp_instr;
    bit           just_reset;
    logic [31:0]  stall_m;
    logic [31:0]  flush_m;
    logic         exp_req;
    logic         hs;
    logic [31:0]  a;
    fetch_entry_t e;

    task automatic model_reset();
        memq.delete();
        q_m.delete();
        drop_m     = 0;
        started_m  = 0;
        fetch_pc_m = 32'h0;
        exp_valid  = 0;
        exp_pc     = '0;
        exp_instr  = '0;
        stall_m    = '0;
        flush_m    = '0;
        just_reset = 1;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            model_reset();
        end else begin
            exp_req = started_m && !branch_taken && (memq.size() + q_m.size() < FQ)
                      && (memq.size() < MO) && (drop_m == 0);
            check("imem_req", 32'(imem_req), 32'(exp_req));
            hs = imem_req && imem_gnt;
            if (hs) check("imem_addr", imem_addr, fetch_pc_m);
            check("valid_ID", 32'(valid_ID), 32'(exp_valid));
            if (exp_valid || just_reset) begin
                check("pc_ID", pc_ID, exp_pc);
                check("instr_ID", instr_ID, exp_instr);
            end
`ifdef FETCH_PERF_CNT_EN
            check("perf_stall_cnt", perf_stall_cnt, stall_m);
            check("perf_flush_cnt", perf_flush_cnt, flush_m);
`endif
            just_reset = 0;

            if (hazard_detected && exp_valid && stall_m != 32'hFFFF_FFFF) stall_m = stall_m + 1;
            if (branch_taken && flush_m != 32'hFFFF_FFFF) flush_m = flush_m + 1;

            // ID sees only what was queued before this edge
            if (branch_taken) begin
                exp_valid = 0;
            end else if (!hazard_detected) begin
                if (q_m.size() > 0) begin
                    e = q_m.pop_front();
                    exp_valid = 1;
                    exp_pc    = e.pc;
                    exp_instr = e.instr;
                end else begin
                    exp_valid = 0;
                end
            end

            if (imem_rvalid) begin
                a = memq.pop_front();
                if (drop_m > 0) drop_m--;
                else q_m.push_back('{pc: a, instr: mem_word(a)});
            end
            if (hs) begin
                memq.push_back(fetch_pc_m);
                fetch_pc_m = fetch_pc_m + 32'd4;
            end
            if (branch_taken) begin
                q_m.delete();
                fetch_pc_m = branch_addr;
                drop_m     = memq.size();
            end
            started_m = 1;
        end
    end

    int          gnt_pct, rv_pct, hz_pct, br_pct;
    int          hz_left = 0;
    logic [31:0] tgt [4];

    task automatic drive();
        imem_gnt    = ($urandom_range(99) < gnt_pct);
        imem_rvalid = !rst && (memq.size() > 0) && ($urandom_range(99) < rv_pct);
        imem_rdata  = imem_rvalid ? mem_word(memq[0]) : $urandom;
        if (hz_left > 0) begin
            hazard_detected = 1'b1;
            hz_left--;
        end else if ($urandom_range(99) < hz_pct) begin
            hazard_detected = 1'b1;
            hz_left = $urandom_range(3);
        end else begin
            hazard_detected = 1'b0;
        end
        branch_taken = ($urandom_range(99) < br_pct);
        tgt[3]       = $urandom & 32'hFFFF_FFFC;
        branch_addr  = tgt[$urandom_range(3)];
    endtask

    initial begin
        tgt[0] = 32'h0000_0100;
        tgt[1] = 32'hFFFF_FFF8;
        tgt[2] = 32'hFFFF_FFFC;
        tgt[3] = 32'h0000_0040;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int p = 0; p < 5; p++) begin
            case (p)
                0: begin gnt_pct = 100; rv_pct = 100; hz_pct = 0;  br_pct = 0; end
                1: begin gnt_pct = 100; rv_pct = 100; hz_pct = 15; br_pct = 0; end
                2: begin gnt_pct = 70;  rv_pct = 60;  hz_pct = 10; br_pct = 5; end
                3: begin gnt_pct = 25;  rv_pct = 50;  hz_pct = 5;  br_pct = 3; end
                default: begin gnt_pct = 90; rv_pct = 90; hz_pct = 12; br_pct = 10; end
            endcase
            if (p == 3) begin
                @(posedge clk);
                #1 rst = 1'b1;
                imem_gnt = 1'b0; imem_rvalid = 1'b0;
                branch_taken = 1'b0; hazard_detected = 1'b0; hz_left = 0;
                repeat (2) @(posedge clk);
                #1 rst = 1'b0;
            end
            for (int c = 0; c < 400; c++) begin
                @(posedge clk);
                #1 drive();
            end
        end
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
